// File: rtl/ctrl_pkg.sv
// Shared decode encodings and the ID/EX control bundle.
// Imported by control_decode and control_pipe.
package ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  localparam logic [2:0] ALUOP_R     = 3'b000;
  localparam logic [2:0] ALUOP_I     = 3'b001;
  localparam logic [2:0] ALUOP_L     = 3'b010;
  localparam logic [2:0] ALUOP_S     = 3'b011;
  localparam logic [2:0] ALUOP_B     = 3'b100;
  localparam logic [2:0] ALUOP_J     = 3'b101;
  localparam logic [2:0] ALUOP_LUI   = 3'b110;
  localparam logic [2:0] ALUOP_AUIPC = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] MEM_W  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_B  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b011;
  localparam logic [2:0] MEM_HU = 3'b100;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       alusrc;
    logic       jump;
    logic       branch;
    logic       jalr;
    logic [1:0] resultsrc;
    logic [3:0] aluop;
    logic [2:0] memctrl;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/control_decode.sv
// Pure combinational RV32I(+M) control decoder.
// Ports: opcode/funct3/funct7 in; ctrl bundle, immsrc, rs use flags, illegal out.
module control_decode
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [6:0]   opcode_i,
  input  logic [2:0]   funct3_i,
  input  logic [6:0]   funct7_i,
  output ctrl_bundle_t ctrl_o,
  output logic [2:0]   immsrc_o,
  output logic         use_rs1_o,
  output logic         use_rs2_o,
  output logic         illegal_o
);

  logic is_r, is_i, is_l, is_s, is_b;
  logic is_jal, is_jalr, is_lui, is_auipc;

  assign is_r     = opcode_i == OP_R;
  assign is_i     = opcode_i == OP_I;
  assign is_l     = opcode_i == OP_L;
  assign is_s     = opcode_i == OP_S;
  assign is_b     = opcode_i == OP_B;
  assign is_jal   = opcode_i == OP_JAL;
  assign is_jalr  = opcode_i == OP_JALR;
  assign is_lui   = opcode_i == OP_LUI;
  assign is_auipc = opcode_i == OP_AUIPC;

  always_comb begin
    ctrl_o    = BUBBLE;
    immsrc_o  = IMM_I;
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    illegal_o = 1'b0;
    unique case (1'b1)
      is_r: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.aluop    = {1'b0, ALUOP_R};
        use_rs1_o       = 1'b1;
        use_rs2_o       = 1'b1;
        if (ENABLE_M && funct7_i == F7_M)
          ctrl_o.aluop[3] = 1'b1;
        else if (funct7_i != F7_BASE &&
                 funct7_i != F7_ALT)
          illegal_o = 1'b1;
      end
      is_i: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.aluop    = {1'b0, ALUOP_I};
        use_rs1_o       = 1'b1;
      end
      is_l: begin
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.memread   = 1'b1;
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.resultsrc = RES_MEM;
        ctrl_o.aluop     = {1'b0, ALUOP_L};
        use_rs1_o        = 1'b1;
        case (funct3_i)
          3'b000:  ctrl_o.memctrl = MEM_B;
          3'b001:  ctrl_o.memctrl = MEM_H;
          3'b010:  ctrl_o.memctrl = MEM_W;
          3'b100:  ctrl_o.memctrl = MEM_BU;
          3'b101:  ctrl_o.memctrl = MEM_HU;
          default: illegal_o      = 1'b1;
        endcase
      end
      is_s: begin
        immsrc_o        = IMM_S;
        ctrl_o.memwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.aluop    = {1'b0, ALUOP_S};
        use_rs1_o       = 1'b1;
        use_rs2_o       = 1'b1;
        case (funct3_i)
          3'b000:  ctrl_o.memctrl = MEM_B;
          3'b001:  ctrl_o.memctrl = MEM_H;
          3'b010:  ctrl_o.memctrl = MEM_W;
          default: illegal_o      = 1'b1;
        endcase
      end
      is_b: begin
        immsrc_o      = IMM_B;
        ctrl_o.branch = 1'b1;
        ctrl_o.aluop  = {1'b0, ALUOP_B};
        use_rs1_o     = 1'b1;
        use_rs2_o     = 1'b1;
      end
      is_jal: begin
        immsrc_o         = IMM_J;
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.jump      = 1'b1;
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.resultsrc = RES_PC4;
        ctrl_o.aluop     = {1'b0, ALUOP_J};
      end
      is_jalr: begin
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.jalr      = 1'b1;
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.resultsrc = RES_PC4;
        ctrl_o.aluop     = {1'b0, ALUOP_J};
        use_rs1_o        = 1'b1;
      end
      is_lui: begin
        immsrc_o        = IMM_U;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.aluop    = {1'b0, ALUOP_LUI};
      end
      is_auipc: begin
        immsrc_o        = IMM_U;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.aluop    = {1'b0, ALUOP_AUIPC};
      end
      default: illegal_o = 1'b1;
    endcase
    // Illegal encodings travel as a bubble and must not cause a stall.
    if (illegal_o) begin
      ctrl_o    = BUBBLE;
      use_rs1_o = 1'b0;
      use_rs2_o = 1'b0;
    end
  end

endmodule

// File: rtl/control_pipe.sv
// Decode control + ID/EX register, load-use hazard and MUL/DIV occupancy.
// Ports: D-stage fields and flushE in; immsrcD/illegalD/stalls and E controls out.
module control_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter bit ENABLE_M   = 1'b1,
  parameter int MUL_LAT    = 1,
  parameter int DIV_LAT    = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            opcodeD,
  input  logic [2:0]            funct3D,
  input  logic [6:0]            funct7D,
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  input  logic [REG_ADDR_W-1:0] rdD,
  input  logic                  flushE,
  output logic [2:0]            immsrcD,
  output logic                  illegalD,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  regwriteE,
  output logic                  memwriteE,
  output logic                  memreadE,
  output logic                  alusrcE,
  output logic                  jumpE,
  output logic                  branchE,
  output logic                  jalrE,
  output logic [1:0]            resultsrcE,
  output logic [3:0]            aluopE,
  output logic [2:0]            memctrlE,
  output logic [REG_ADDR_W-1:0] rdE,
  output logic                  mdbusyE
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  ctrl_bundle_t          dec;
  ctrl_bundle_t          ex_q, ex_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  use1, use2;
  logic                  lu_haz, md_hold;

  control_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_dec (
    .opcode_i  (opcodeD),
    .funct3_i  (funct3D),
    .funct7_i  (funct7D),
    .ctrl_o    (dec),
    .immsrc_o  (immsrcD),
    .use_rs1_o (use1),
    .use_rs2_o (use2),
    .illegal_o (illegalD)
  );

  assign md_hold = cnt_q != '0;
  assign lu_haz  = ex_q.memread && rd_q != '0 &&
                   ((use1 && rd_q == rs1D) ||
                    (use2 && rd_q == rs2D));

  assign stallF = lu_haz || md_hold;
  assign stallD = lu_haz || md_hold;

  always_comb begin
    ex_d  = ex_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (md_hold) begin
      cnt_d = cnt_q - 1'b1;
    end else if (flushE || lu_haz) begin
      ex_d = BUBBLE;
      rd_d = '0;
    end else begin
      ex_d = dec;
      rd_d = illegalD ? '0 : rdD;
      // funct3[2] splits MUL* from DIV*/REM*.
      if (dec.aluop[3])
        cnt_d = funct3D[2] ? DIV_CNT : MUL_CNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= BUBBLE;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign regwriteE  = ex_q.regwrite;
  assign memwriteE  = ex_q.memwrite;
  assign memreadE   = ex_q.memread;
  assign alusrcE    = ex_q.alusrc;
  assign jumpE      = ex_q.jump;
  assign branchE    = ex_q.branch;
  assign jalrE      = ex_q.jalr;
  assign resultsrcE = ex_q.resultsrc;
  assign aluopE     = ex_q.aluop;
  assign memctrlE   = ex_q.memctrl;
  assign rdE        = rd_q;
  assign mdbusyE    = md_hold;

  // A branch cannot resolve while a MUL/DIV owns Execute.
  a_no_flush_in_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(flushE && md_hold)
  );

endmodule

// File: tb/tb_control_pipe.sv
// Scoreboard bench for control_pipe against a spec-level model.
// Directed hazard/MUL-DIV/flush/reset cases plus random traffic.
module tb_control_pipe;

  typedef struct packed {
    logic       rw, mw, mr, as, j, b, jr;
    logic [1:0] rs;
    logic [3:0] ao;
    logic [2:0] mc;
    logic [4:0] rd;
    logic       busy;
  } ex_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] r1, r2, rd;
  } ins_t;

  logic       clk = 0;
  logic       rst_n = 0;
  logic [6:0] opcodeD = 0;
  logic [2:0] funct3D = 0;
  logic [6:0] funct7D = 0;
  logic [4:0] rs1D = 0, rs2D = 0, rdD = 0;
  logic       flushE = 0;

  logic [2:0] immsrcD;
  logic       illegalD, stallF, stallD;
  logic       regwriteE, memwriteE, memreadE, alusrcE;
  logic       jumpE, branchE, jalrE, mdbusyE;
  logic [1:0] resultsrcE;
  logic [3:0] aluopE;
  logic [2:0] memctrlE;
  logic [4:0] rdE;

  logic [2:0] n_imm;
  logic       n_ill, n_sf, n_sd;
  logic       n_rw, n_mw, n_mr, n_as, n_j, n_b, n_jr, n_busy;
  logic [1:0] n_rs;
  logic [3:0] n_ao;
  logic [2:0] n_mc;
  logic [4:0] n_rd;

  control_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .opcodeD(opcodeD), .funct3D(funct3D),
    .funct7D(funct7D), .rs1D(rs1D),
    .rs2D(rs2D), .rdD(rdD), .flushE(flushE),
    .immsrcD(immsrcD), .illegalD(illegalD),
    .stallF(stallF), .stallD(stallD),
    .regwriteE(regwriteE), .memwriteE(memwriteE),
    .memreadE(memreadE), .alusrcE(alusrcE),
    .jumpE(jumpE), .branchE(branchE),
    .jalrE(jalrE), .resultsrcE(resultsrcE),
    .aluopE(aluopE), .memctrlE(memctrlE),
    .rdE(rdE), .mdbusyE(mdbusyE)
  );

  control_pipe #(.ENABLE_M(1'b0)) dut_nom (
    .clk(clk), .rst_n(rst_n),
    .opcodeD(opcodeD), .funct3D(funct3D),
    .funct7D(funct7D), .rs1D(rs1D),
    .rs2D(rs2D), .rdD(rdD), .flushE(1'b0),
    .immsrcD(n_imm), .illegalD(n_ill),
    .stallF(n_sf), .stallD(n_sd),
    .regwriteE(n_rw), .memwriteE(n_mw),
    .memreadE(n_mr), .alusrcE(n_as),
    .jumpE(n_j), .branchE(n_b),
    .jalrE(n_jr), .resultsrcE(n_rs),
    .aluopE(n_ao), .memctrlE(n_mc),
    .rdE(n_rd), .mdbusyE(n_busy)
  );

  always #5 clk = ~clk;

  int  n_run = 0;
  int  n_fail = 0;
  ex_t exq[$];
  ex_t me = '0;
  int  busy = 0;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] x);
    n_run++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, x);
    end
  endtask

  function automatic ex_t act_e();
    return {regwriteE, memwriteE, memreadE,
            alusrcE, jumpE, branchE, jalrE,
            resultsrcE, aluopE, memctrlE,
            rdE, mdbusyE};
  endfunction

  // Reference decode from the instruction-class rules.
  task automatic rdec(input ins_t in, input bit enm,
                      output ex_t e, output bit ill,
                      output bit u1, output bit u2,
                      output logic [2:0] imm);
    logic [2:0] lmap [8] = '{3'd2, 3'd1, 3'd0, 3'd0,
                             3'd3, 3'd4, 3'd0, 3'd0};
    logic [2:0] smap [3] = '{3'd2, 3'd1, 3'd0};
    e = '0; ill = 0; u1 = 0; u2 = 0; imm = 3'd0;
    case (in.op)
      7'h33: begin
        e.rw = 1; u1 = 1; u2 = 1;
        if (enm && in.f7 == 7'h01) e.ao = 4'b1000;
        else if (in.f7 != 7'h00 && in.f7 != 7'h20)
          ill = 1;
      end
      7'h13: begin
        e.rw = 1; e.as = 1; e.ao = 4'd1; u1 = 1;
      end
      7'h03: begin
        if (in.f3 inside {3'd3, 3'd6, 3'd7}) ill = 1;
        else begin
          e.rw = 1; e.mr = 1; e.as = 1;
          e.rs = 2'd1; e.ao = 4'd2; u1 = 1;
          e.mc = lmap[in.f3];
        end
      end
      7'h23: begin
        imm = 3'd1;
        if (in.f3 > 3'd2) ill = 1;
        else begin
          e.mw = 1; e.as = 1; e.ao = 4'd3;
          u1 = 1; u2 = 1;
          e.mc = smap[in.f3];
        end
      end
      7'h63: begin
        imm = 3'd2; e.b = 1; e.ao = 4'd4;
        u1 = 1; u2 = 1;
      end
      7'h6f: begin
        imm = 3'd4; e.j = 1; e.rw = 1;
        e.rs = 2'd2; e.as = 1; e.ao = 4'd5;
      end
      7'h67: begin
        e.jr = 1; e.rw = 1; e.rs = 2'd2;
        e.as = 1; e.ao = 4'd5; u1 = 1;
      end
      7'h37: begin
        imm = 3'd3; e.rw = 1; e.as = 1; e.ao = 4'd6;
      end
      7'h17: begin
        imm = 3'd3; e.rw = 1; e.as = 1; e.ao = 4'd7;
      end
      default: ill = 1;
    endcase
    if (ill) begin
      e = '0; u1 = 0; u2 = 0;
    end else begin
      e.rd = in.rd;
    end
  endtask

  // One Decode cycle: drive, check D outputs, queue next E state.
  task automatic step(input ins_t in, input bit fl,
                      output bit st, output bit ds);
    ex_t e, e0;
    bit ill, u1, u2, ill0, x1, x2, lu;
    logic [2:0] imm, imm0;
    opcodeD = in.op; funct3D = in.f3;
    funct7D = in.f7; rs1D = in.r1;
    rs2D = in.r2; rdD = in.rd;
    flushE = fl && busy == 0;
    @(negedge clk);
    rdec(in, 1'b1, e, ill, u1, u2, imm);
    rdec(in, 1'b0, e0, ill0, x1, x2, imm0);
    lu = me.mr && me.rd != 0 &&
         ((u1 && me.rd == in.r1) ||
          (u2 && me.rd == in.r2));
    st = lu || busy > 0;
    ds = stallD;
    chk("stallF", 32'(stallF), 32'(st));
    chk("stallD", 32'(stallD), 32'(st));
    chk("illegalD", 32'(illegalD), 32'(ill));
    chk("immsrcD", 32'(immsrcD), 32'(imm));
    chk("illegalD_noM", 32'(n_ill), 32'(ill0));
    if (busy > 0) begin
      busy--;
    end else if (flushE || lu) begin
      me = '0;
    end else begin
      me = e;
      if (e.ao[3]) busy = in.f3[2] ? 31 : 0;
    end
    me.busy = busy != 0;
    exq.push_back(me);
    @(posedge clk); #2;
    flushE = 0;
  endtask

  task automatic issue(input ins_t in, input bit fl,
                       output int nst);
    bit st, ds;
    nst = 0;
    for (int i = 0; i < 64; i++) begin
      step(in, fl && i == 0, st, ds);
      if (ds) nst++;
      if (!st) return;
    end
    chk("issue_timeout", 32'd1, 32'd0);
  endtask

  function automatic ins_t mk(input logic [6:0] op,
                              input logic [2:0] f3,
                              input logic [6:0] f7,
                              input logic [4:0] r1,
                              input logic [4:0] r2,
                              input logic [4:0] rd);
    ins_t r;
    r.op = op; r.f3 = f3; r.f7 = f7;
    r.r1 = r1; r.r2 = r2; r.rd = rd;
    return r;
  endfunction

  function automatic ins_t rnd();
    ins_t r;
    int k;
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03,
                            7'h23, 7'h63, 7'h6f,
                            7'h67, 7'h37, 7'h17};
    k = $urandom_range(0, 39);
    r.f3 = 3'($urandom);
    r.f7 = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
    r.r1 = 5'($urandom_range(0, 3));
    r.r2 = 5'($urandom_range(0, 3));
    r.rd = 5'($urandom_range(0, 3));
    if (k < 36) r.op = ops[k % 9];
    else if (k == 36) begin
      r.op = 7'h33; r.f7 = 7'h01;
    end else if (k == 37) r.op = 7'($urandom);
    else begin
      r.op = 7'h33; r.f7 = 7'($urandom);
    end
    return r;
  endfunction

  initial begin : monitor
    ex_t x;
    forever begin
      @(posedge clk); #1;
      if (exq.size() != 0) begin
        x = exq.pop_front();
        chk("E_bundle", 32'(act_e()), 32'(x));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    ins_t lw5, add6, nop, in;
    int n;
    bit st, ds;
    lw5  = mk(7'h03, 3'd2, 7'h00, 5'd1, 5'd0, 5'd5);
    add6 = mk(7'h33, 3'd0, 7'h00, 5'd5, 5'd2, 5'd6);
    nop  = mk(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_E", 32'(act_e()), 32'd0);
    chk("reset_mdbusy", 32'(mdbusyE), 32'd0);
    chk("reset_stallF", 32'(stallF), 32'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #2;

    issue(lw5, 0, n);
    chk("lw_no_stall", 32'(n), 32'd0);
    issue(add6, 0, n);
    chk("lu_stall_cycles", 32'(n), 32'd1);

    issue(lw5, 0, n);
    issue(mk(7'h37, 3'd0, 7'h00, 5'd5, 5'd5, 5'd5), 0, n);
    chk("lw_lui_stall", 32'(n), 32'd0);
    issue(mk(7'h03, 3'd2, 7'h00, 5'd1, 5'd0, 5'd0), 0, n);
    issue(mk(7'h33, 3'd0, 7'h00, 5'd0, 5'd0, 5'd6), 0, n);
    chk("lw_x0_stall", 32'(n), 32'd0);

    issue(mk(7'h33, 3'd0, 7'h01, 5'd1, 5'd2, 5'd3), 0, n);
    chk("mul_stall", 32'(n), 32'd0);
    issue(mk(7'h33, 3'd4, 7'h01, 5'd1, 5'd2, 5'd4), 0, n);
    chk("div_issue_stall", 32'(n), 32'd0);
    issue(add6, 0, n);
    chk("div_stall_cycles", 32'(n), 32'd31);

    issue(mk(7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0), 1, n);
    issue(lw5, 0, n);
    issue(add6, 1, n);
    chk("flush_lu_stall", 32'(n), 32'd1);

    issue(mk(7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0), 0, n);
    chk("illegal_op_stall", 32'(n), 32'd0);
    issue(mk(7'h03, 3'd7, 7'h00, 5'd1, 5'd0, 5'd5), 0, n);
    issue(add6, 0, n);
    chk("illegal_lw_stall", 32'(n), 32'd0);

    issue(mk(7'h33, 3'd5, 7'h01, 5'd1, 5'd2, 5'd7), 0, n);
    repeat (4) step(add6, 0, st, ds);
    rst_n = 0;
    #1;
    chk("mid_div_reset_E", 32'(act_e()), 32'd0);
    chk("mid_div_reset_busy", 32'(mdbusyE), 32'd0);
    chk("mid_div_reset_stall", 32'(stallD), 32'd0);
    me = '0;
    busy = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #2;
    issue(add6, 0, n);
    chk("post_reset_add_stall", 32'(n), 32'd0);

    in = nop;
    st = 0;
    for (int i = 0; i < 400; i++) begin
      if (!st) in = rnd();
      step(in, $urandom_range(0, 7) == 0, st, ds);
    end
    step(nop, 0, st, ds);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
